decimal_request_arbiter: RTL

//  Round-robin arbiter and sequencer for ten decimal request lines (keys/channels 0-9).

---
 rtl/decimal_request_arbiter.sv | 123 ++++++++++++
 1 files changed

// File: rtl/decimal_request_arbiter.sv
// Round-robin arbiter over ten decimal request lines; the winner's 4-bit index is offered one cycle after sampling
// and held until code_ready, then the grant stays until that requester drops. Optional forced release: DRA_TIMEOUT_EN.
module decimal_request_arbiter #(
  parameter int N_REQ   = 10,
  parameter int CNT_W   = 8,
  parameter int TIMEOUT = 255
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [N_REQ-1:0] req,
  output logic [3:0]       code,
  output logic             code_valid,
  input  logic             code_ready,
  output logic [N_REQ-1:0] gnt,
  output logic             busy,
  output logic [CNT_W-1:0] grant_count,
  output logic             timeout
);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] OFFER = 2'd1;
  localparam logic [1:0] HOLD  = 2'd2;

  localparam logic [3:0] LAST_CODE = 4'(N_REQ - 1);

  logic [1:0]       state;
  logic [3:0]       ptr;
  logic [3:0]       sel;
  logic             sel_found;
  logic [4:0]       idx;
  logic [N_REQ-1:0] sel_onehot;
  logic [3:0]       ptr_after_code;
  logic             hold_done;

  // Scan starts at ptr and wraps, so the line just served has the lowest priority.
  always_comb begin
    sel       = ptr;
    sel_found = 1'b0;
    idx       = '0;
    for (int i = 0; i < N_REQ; i++) begin
      idx = {1'b0, ptr} + 5'(i);
      if (idx >= 5'(N_REQ)) begin
        idx = idx - 5'(N_REQ);
      end
      if (!sel_found && req[idx[3:0]]) begin
        sel       = idx[3:0];
        sel_found = 1'b1;
      end
    end
  end

  assign sel_onehot     = {{(N_REQ-1){1'b0}}, 1'b1} << sel;
  assign ptr_after_code = (code == LAST_CODE) ? 4'd0 : code + 4'd1;
  assign busy           = (state != IDLE);

`ifdef DRA_TIMEOUT_EN
  localparam int HC_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  logic [HC_W-1:0] hold_cnt;
  logic            force_rel;

  assign force_rel = (state == HOLD) && req[code] && (hold_cnt == HC_W'(TIMEOUT - 1));
  assign hold_done = (state == HOLD) && (!req[code] || force_rel);

  always_ff @(posedge clk) begin
    if (rst) begin
      hold_cnt <= '0;
      timeout  <= 1'b0;
    end else begin
      timeout <= force_rel;
      if (state != HOLD || force_rel) begin
        hold_cnt <= '0;
      end else begin
        hold_cnt <= hold_cnt + HC_W'(1);
      end
    end
  end
`else
  assign hold_done = (state == HOLD) && !req[code];
  assign timeout   = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      ptr         <= '0;
      code        <= '0;
      code_valid  <= 1'b0;
      gnt         <= '0;
      grant_count <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (|req) begin
            code       <= sel;
            gnt        <= sel_onehot;
            code_valid <= 1'b1;
            state      <= OFFER;
          end
        end
        OFFER: begin
          // A requester dropping here does not cancel the offer; HOLD then releases next cycle.
          if (code_ready) begin
            code_valid  <= 1'b0;
            grant_count <= grant_count + CNT_W'(1);
            state       <= HOLD;
          end
        end
        HOLD: begin
          if (hold_done) begin
            gnt   <= '0;
            ptr   <= ptr_after_code;
            state <= IDLE;
          end
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule
